// File: rtl/mastermind_grader.sv
// rtl/mastermind_grader.sv - Mastermind round counter and serial Znarly/Zood grader
module mastermind_grader #(
    parameter int NUM_ROUNDS = 8,
    parameter int SHAPE_W    = 3,
    parameter int NUM_SHAPES = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 c_clear,
    input  logic                 c_en,
    input  logic                 f_load,
    input  logic                 f_clear,
    input  logic [4*SHAPE_W-1:0] guess,
    input  logic [4*SHAPE_W-1:0] master,
    output logic [3:0]           round_count,
    output logic [2:0]           znarly,
    output logic [2:0]           zood,
    output logic                 feedback_valid,
    output logic                 busy,
    output logic                 won,
    output logic                 lost
);

    typedef enum logic [1:0] {IDLE, EXACT, COUNT, DONE} state_t;

    localparam logic [SHAPE_W:0]   SHAPE_LIMIT = (SHAPE_W+1)'(NUM_SHAPES);
    localparam logic [SHAPE_W-1:0] LAST_SHAPE  = SHAPE_W'(NUM_SHAPES - 1);
    localparam logic [3:0]         ROUND_LIMIT = 4'(NUM_ROUNDS);

    state_t               state;
    state_t               state_next;
    logic [4*SHAPE_W-1:0] g_r;
    logic [4*SHAPE_W-1:0] m_r;
    logic [SHAPE_W-1:0]   s;
    logic [2:0]           exact;
    logic [2:0]           total;
    logic [2:0]           exact_now;
    logic [2:0]           g_cnt;
    logic [2:0]           m_cnt;
    logic [2:0]           shape_min;
    logic                 start;

    assign start = f_load && !f_clear && (state == IDLE || state == DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (f_clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (f_load) state_next = EXACT;
                EXACT:      state_next = COUNT;
                COUNT:      if (s == LAST_SHAPE) state_next = DONE;
                default:    state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state == EXACT) || (state == COUNT);
    end

    // Invalid codes are excluded from exact matches; the shape sweep only visits valid codes.
    always_comb begin
        exact_now = '0;
        g_cnt     = '0;
        m_cnt     = '0;
        for (int i = 0; i < 4; i++) begin
            if (g_r[SHAPE_W*i +: SHAPE_W] == m_r[SHAPE_W*i +: SHAPE_W] &&
                {1'b0, g_r[SHAPE_W*i +: SHAPE_W]} < SHAPE_LIMIT)
                exact_now = exact_now + 3'd1;
            if (g_r[SHAPE_W*i +: SHAPE_W] == s)
                g_cnt = g_cnt + 3'd1;
            if (m_r[SHAPE_W*i +: SHAPE_W] == s)
                m_cnt = m_cnt + 3'd1;
        end
        shape_min = (g_cnt < m_cnt) ? g_cnt : m_cnt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            g_r            <= '0;
            m_r            <= '0;
            s              <= '0;
            exact          <= '0;
            total          <= '0;
            znarly         <= '0;
            zood           <= '0;
            feedback_valid <= 1'b0;
            won            <= 1'b0;
            lost           <= 1'b0;
        end else if (f_clear) begin
            znarly         <= '0;
            zood           <= '0;
            feedback_valid <= 1'b0;
            won            <= 1'b0;
            lost           <= 1'b0;
        end else if (start) begin
            g_r            <= guess;
            m_r            <= master;
            s              <= '0;
            exact          <= '0;
            total          <= '0;
            feedback_valid <= 1'b0;
            won            <= 1'b0;
            lost           <= 1'b0;
        end else begin
            case (state)
                EXACT: begin
                    exact <= exact_now;
                    s     <= '0;
                end
                COUNT: begin
                    total <= total + shape_min;
                    s     <= s + 1'b1;
                end
                DONE: begin
                    // Capture once on DONE entry so later counter changes cannot alter lost.
                    if (!feedback_valid) begin
                        znarly         <= exact;
                        zood           <= total - exact;
                        won            <= (exact == 3'd4);
                        lost           <= (exact != 3'd4) && (round_count == ROUND_LIMIT);
                        feedback_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset || c_clear) begin
            round_count <= '0;
        end else if (c_en && round_count != ROUND_LIMIT) begin
            round_count <= round_count + 4'd1;
        end
    end

endmodule
